// File: rtl/writeback.sv
// Y86 writeback stage: latches completed instructions, commits them to an 8 x 32 register
// file through one write port, and tracks processor status and retired-instruction count.
module writeback (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [31:0] valE,
    input  logic [31:0] valM,
    output logic        ready,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [31:0] rdA,
    output logic [31:0] rdB,
    output logic [1:0]  status,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT_E,
        S_COMMIT_M,
        S_HALTED
    } state_t;

    localparam logic [3:0] REG_NONE = 4'hF;

    state_t      r_state;
    logic [31:0] r_rf [8];
    logic [3:0]  r_icode;
    logic [3:0]  r_rA;
    logic [3:0]  r_rB;
    logic [31:0] r_valE;
    logic [31:0] r_valM;
    logic [1:0]  r_status;
    logic [31:0] r_retired;

    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic        w_accept;
    logic        w_halt_acc;
    logic        w_retire_commit;
    logic        w_we;
    logic [2:0]  w_waddr;
    logic [31:0] w_wdata;
    state_t      w_acc_state;
    logic [1:0]  w_acc_status;

    always_comb begin
        w_dstE = REG_NONE;
        case (r_icode)
            4'h2, 4'h3, 4'h6:         w_dstE = r_rB;
            4'h8, 4'h9, 4'hA, 4'hB:   w_dstE = 4'h4;
            default:                  w_dstE = REG_NONE;
        endcase
        w_dstM = (r_icode == 4'h5 || r_icode == 4'hB) ? r_rA : REG_NONE;
    end

    assign ready = (r_state == S_IDLE)
                || (r_state == S_COMMIT_E && w_dstM == REG_NONE)
                || (r_state == S_COMMIT_M);

    assign w_accept        = in_valid && ready;
    assign w_halt_acc      = w_accept && (icode == 4'h0 || icode > 4'hB);
    assign w_retire_commit = (r_state == S_COMMIT_E && w_dstM == REG_NONE)
                          || (r_state == S_COMMIT_M);

    // Single write port; indices 8..E are silently dropped, F means no destination.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = 3'd0;
        w_wdata = 32'd0;
        if (r_state == S_COMMIT_E && !w_dstE[3]) begin
            w_we    = 1'b1;
            w_waddr = w_dstE[2:0];
            w_wdata = r_valE;
        end else if (r_state == S_COMMIT_M && !w_dstM[3]) begin
            w_we    = 1'b1;
            w_waddr = w_dstM[2:0];
            w_wdata = r_valM;
        end
    end

    always_comb begin
        w_acc_state  = S_COMMIT_E;
        w_acc_status = 2'd0;
        if (icode == 4'h0) begin
            w_acc_state  = S_HALTED;
            w_acc_status = 2'd1;
        end else if (icode > 4'hB) begin
            w_acc_state  = S_HALTED;
            w_acc_status = 2'd2;
        end
    end

    // Read ports bypass the write committing at the coming edge.
    always_comb begin
        rdA = 32'd0;
        rdB = 32'd0;
        if (!srcA[3]) rdA = (w_we && w_waddr == srcA[2:0]) ? w_wdata : r_rf[srcA[2:0]];
        if (!srcB[3]) rdB = (w_we && w_waddr == srcB[2:0]) ? w_wdata : r_rf[srcB[2:0]];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_rf[i] <= 32'd0;
        end else if (w_we) begin
            r_rf[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_icode <= icode;
            r_rA    <= rA;
            r_rB    <= rB;
            r_valE  <= valE;
            r_valM  <= valM;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_status  <= 2'd0;
            r_retired <= 32'd0;
        end else begin
            r_retired <= r_retired + 32'(w_retire_commit) + 32'(w_halt_acc);
            if (w_accept) r_status <= w_acc_status;
            case (r_state)
                S_IDLE:     r_state <= w_accept ? w_acc_state : S_IDLE;
                S_COMMIT_E: begin
                    if (w_dstM != REG_NONE) r_state <= S_COMMIT_M;
                    else                    r_state <= w_accept ? w_acc_state : S_IDLE;
                end
                S_COMMIT_M: r_state <= w_accept ? w_acc_state : S_IDLE;
                default:    r_state <= S_HALTED;
            endcase
        end
    end

    assign status  = r_status;
    assign halted  = (r_status != 2'd0);
    assign retired = r_retired;

endmodule

// File: doc/writeback.md
# writeback

Final pipeline stage of the Y86 core, directly downstream of the memory stage. It captures each completed instruction (icode, rA, rB, valE, valM) and commits results to an internal 8 x 32-bit register file through a single write port, taking two commit cycles when an instruction writes both valE and valM. It provides the two combinational read ports, with write-through bypass, that decode uses. It also tracks processor status on halt or illegal icode and counts retired instructions.

## Interface
- No parameters; the register file is fixed at 8 x 32 bits, and `%esp` is register 4.
- `clock`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  memory stage presents a finished instruction (memory stage's `stall` deasserted).
- `icode`  in  4  instruction code from memory stage.
- `rA`, `rB`  in  4 each  register specifiers; 4'hF = none.
- `valE`  in  32  ALU/stack-pointer result.
- `valM`  in  32  memory read result.
- `ready`  out  1  combinational; stage can accept this cycle.
- `srcA`, `srcB`  in  4 each  decode read addresses.
- `rdA`, `rdB`  out  32 each  combinational read data.
- `status`  out  2  0 = AOK, 1 = HLT, 2 = INS.
- `halted`  out  1  status != AOK.
- `retired`  out  32  count of committed instructions.

## Operation
- Destination decode (from latched fields):
  - dstE = rB for icode 2, 3, 6.
  - dstE = 4 for icode 8, 9, A, B.
  - dstE = F otherwise.
  - dstM = rA for icode 5, B; F otherwise.
  - Conditional-move suppression is done upstream by passing rB = F.
- States:
  - IDLE
  - COMMIT_E
  - COMMIT_M
  - HALTED
- Accept: `in_valid && ready` at an edge latches all five inputs.
  - Next state is COMMIT_E for icode 1–B.
  - Next state is HALTED with status = 1 for icode 0.
  - Next state is HALTED with status = 2 for icode > B.
- COMMIT_E: at the edge, write valE to dstE if dstE != F.
  - Then go to COMMIT_M if dstM != F.
  - Otherwise retire; the next state is COMMIT_E if a new instruction is accepted on the same edge, else IDLE.
- COMMIT_M: at the edge, write valM to dstM and retire. The next state is COMMIT_E on a simultaneous accept, else IDLE.
- `ready` = (IDLE) or (COMMIT_E and dstM == F) or (COMMIT_M). It is 0 in HALTED.
- Retire: `retired` += 1, wrapping modulo 2^32. A halt or illegal icode also counts once, at its accept edge.
- Instructions with no destination (1, 4, 7) still spend one COMMIT_E cycle and retire.
- popl %esp (rA = 4): the E write of valE to reg 4 happens first, then the M write of valM; the final value is valM.
- Reads:
  - `rdX` = 0 if srcX = F or srcX > 7.
  - `rdX` = write data if a write to srcX commits at the coming edge (bypass).
  - Otherwise `rdX` = the register content.
- Writes to index > 7 are ignored except F, which means none.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE and all 8 registers = 0.
  - status = 0, halted = 0, retired = 0.
  - `ready` = 1 combinationally after reset releases.
- Latency: a single-destination instruction accepted at edge N writes the register file at edge N+1. It is visible on `rdX` through the register from cycle N+1, and via bypass during cycle N→N+1.
- Dual-destination instructions (popl) write at N+1 (E) and N+2 (M). `ready` is 0 during cycle N→N+1.
- Throughput: 1 instruction per cycle for single- or no-destination instructions, and 1 per 2 cycles for popl.
- HALTED is sticky until reset. `halted` rises the cycle after the accept edge. `in_valid` is ignored while halted.
- Reset asserted mid-COMMIT_M: the pending M write is dropped, and all registers read 0 after reset.
- `retired` updates on the same edge as the final write.

## Test plan
- Reset, then irmovl (icode 3, rB = 2, valE = 0x1234), accepted at edge 1 → rdA (srcA = 2) = 0x1234 from cycle 1; retired = 1.
- popl %esp (icode B, rA = 4, valE = 0x104, valM = 0xCAFE) → ready = 0 for one cycle; reg4 = 0x104 after edge N+1 and 0xCAFE after edge N+2; retired increments once.
- Four back-to-back OPl (icode 6, rB = 0..3, valE = 10..13), in_valid held high → one accept per cycle; registers 0..3 = 10..13; retired = 4 after 5 edges.
- halt (icode 0) followed by in_valid with irmovl → status = 1, halted = 1, ready = 0; the irmovl is never written; retired = 1.
- icode 4'hE accepted → status = 2, halted = 1.
- mrmovl (icode 5, rA = 1, valM = 0x55), with reset asserted during COMMIT_E → reg1 = 0; state IDLE; retired = 0; ready = 1 after release.
